// File: rtl/cpu_debug_pkg.sv
// Shared types and constants for the CPU debug command path.
package cpu_debug_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    localparam int IR_OCIMEM = 0;
    localparam int IR_TRACE  = 1;
    localparam int IR_BREAK  = 2;
    localparam int IR_RSVD   = 3;

    localparam int COUNT_W = 16;

endpackage

// File: rtl/cpu_debug_sync_edge.sv
// TCK-level synchroniser with rising-edge pulse; pulse = SYNC_STAGES cycles after first sample.
// Pulses are masked until SYNC_STAGES+1 cycles after reset release; no backpressure.
module cpu_debug_sync_edge
    import cpu_debug_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic pulse
);

    localparam int ARM_CYC = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_CYC + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [ARM_W-1:0]       arm_q,  arm_d;
    logic                   armed;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        hist_d = sync_q[SYNC_STAGES-1];
        arm_d  = arm_q;
        if (arm_q != ARM_W'(ARM_CYC)) begin
            arm_d = arm_q + 1'b1;
        end
    end

    // Masking lets the history flop absorb a level already high at reset release.
    assign armed = (arm_q == ARM_W'(ARM_CYC));
    assign pulse = sync_q[SYNC_STAGES-1] & ~hist_q & armed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            arm_q  <= arm_d;
        end
    end

endmodule

// File: rtl/cpu_debug_cmd_sync.sv
// Routes synchronised JTAG DR updates to NUM_CH debug channels; cmd_valid SYNC_STAGES cycles after vs_udr.
// One command held per valid/ready; updates arriving while pending are dropped (ovf_err). CPU_DEBUG_CMD_COUNT_EN adds cmd_count.
module cpu_debug_cmd_sync
    import cpu_debug_pkg::*;
#(
    parameter int IR_W        = 2,
    parameter int SR_W        = 38,
    parameter int NUM_CH      = 2,
    parameter int CH_W        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [IR_W-1:0]    ir_in,
    input  logic [SR_W-1:0]    sr,
    input  logic               vs_uir,
    input  logic               vs_udr,
    output logic [SR_W-1:0]    jdo,
    output logic [IR_W-1:0]    cmd_ir,
    output logic [NUM_CH-1:0]  cmd_valid,
    input  logic [NUM_CH-1:0]  cmd_ready,
    output logic               ovf_err,
    output logic               ch_err,
    input  logic               err_clr,
    output logic [COUNT_W-1:0] cmd_count
);

    logic uir_p, udr_p;

    cpu_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (vs_uir),
        .pulse   (uir_p)
    );

    cpu_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (vs_udr),
        .pulse   (udr_p)
    );

    state_e            state_q,     state_d;
    logic [IR_W-1:0]   ir_q,        ir_d;
    logic [SR_W-1:0]   jdo_q,       jdo_d;
    logic [IR_W-1:0]   cmd_ir_q,    cmd_ir_d;
    logic [NUM_CH-1:0] cmd_valid_q, cmd_valid_d;
    logic              ovf_err_q,   ovf_err_d;
    logic              ch_err_q,    ch_err_d;

    logic [CH_W-1:0] ch;
    logic            ch_bad;
    logic            done;
    logic            accept;

    assign ch     = sr[SR_W-1 -: CH_W];
    // Extra bit keeps the compare correct when NUM_CH == 2**CH_W.
    assign ch_bad = ({1'b0, ch} >= (CH_W+1)'(NUM_CH));
    assign done   = |(cmd_valid_q & cmd_ready);

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        jdo_d       = jdo_q;
        cmd_ir_d    = cmd_ir_q;
        cmd_valid_d = cmd_valid_q;
        ovf_err_d   = ovf_err_q;
        ch_err_d    = ch_err_q;
        accept      = 1'b0;

        if (uir_p) begin
            ir_d = ir_in;
        end
        if (err_clr) begin
            ovf_err_d = 1'b0;
            ch_err_d  = 1'b0;
        end
        if (done) begin
            cmd_valid_d = '0;
            state_d     = IDLE;
        end
        if (udr_p) begin
            if (ch_bad) begin
                ch_err_d = 1'b1;
            end else if (state_q == IDLE || done) begin
                accept      = 1'b1;
                jdo_d       = sr;
                cmd_ir_d    = ir_q;
                cmd_valid_d = NUM_CH'(1) << ch;
                state_d     = PEND;
            end else begin
                ovf_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ir_q        <= '0;
            jdo_q       <= '0;
            cmd_ir_q    <= '0;
            cmd_valid_q <= '0;
            ovf_err_q   <= 1'b0;
            ch_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            jdo_q       <= jdo_d;
            cmd_ir_q    <= cmd_ir_d;
            cmd_valid_q <= cmd_valid_d;
            ovf_err_q   <= ovf_err_d;
            ch_err_q    <= ch_err_d;
        end
    end

`ifdef CPU_DEBUG_CMD_COUNT_EN
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q != {COUNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cmd_count = cnt_q;
`else
    assign cmd_count = '0;
`endif

    assign jdo       = jdo_q;
    assign cmd_ir    = cmd_ir_q;
    assign cmd_valid = cmd_valid_q;
    assign ovf_err   = ovf_err_q;
    assign ch_err    = ch_err_q;

endmodule

// File: tb/tb_cpu_debug_cmd_sync.sv
// Directed bench for cpu_debug_cmd_sync with default parameters (SYNC_STAGES=2, NUM_CH=2).
module tb_cpu_debug_cmd_sync;

    localparam int IR_W   = 2;
    localparam int SR_W   = 38;
    localparam int NUM_CH = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [IR_W-1:0]   ir_in;
    logic [SR_W-1:0]   sr;
    logic              vs_uir, vs_udr;
    logic [SR_W-1:0]   jdo;
    logic [IR_W-1:0]   cmd_ir;
    logic [NUM_CH-1:0] cmd_valid;
    logic [NUM_CH-1:0] cmd_ready;
    logic              ovf_err, ch_err, err_clr;
    logic [15:0]       cmd_count;

    int vectors     = 0;
    int miscompares = 0;

    cpu_debug_cmd_sync dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ir_in     (ir_in),
        .sr        (sr),
        .vs_uir    (vs_uir),
        .vs_udr    (vs_udr),
        .jdo       (jdo),
        .cmd_ir    (cmd_ir),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .ovf_err   (ovf_err),
        .ch_err    (ch_err),
        .err_clr   (err_clr),
        .cmd_count (cmd_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle vs_udr level; returns just after the edge where the command becomes visible.
    task automatic udr(input logic [SR_W-1:0] val);
        sr     = val;
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        tick(2);
    endtask

    localparam logic [SR_W-1:0] W_BEEF = {4'd1, 34'h0DEADBEEF};
    localparam logic [SR_W-1:0] W_111  = {4'd0, 34'h111};
    localparam logic [SR_W-1:0] W_333  = {4'd0, 34'h333};
    localparam logic [SR_W-1:0] W_444  = {4'd1, 34'h444};
    localparam logic [SR_W-1:0] W_555  = {4'd0, 34'h555};
    localparam logic [SR_W-1:0] W_666  = {4'd1, 34'h666};

    initial begin
        logic [15:0] exp_cnt;
`ifdef CPU_DEBUG_CMD_COUNT_EN
        exp_cnt = 16'd6;
`else
        exp_cnt = 16'd0;
`endif
        reset_n   = 1'b0;
        ir_in     = '0;
        sr        = '0;
        vs_uir    = 1'b0;
        vs_udr    = 1'b1;
        cmd_ready = '0;
        err_clr   = 1'b0;
        tick(3);
        chk("rst_valid", 64'(cmd_valid), 64'h0);
        chk("rst_jdo",   64'(jdo),       64'h0);
        chk("rst_cmdir", 64'(cmd_ir),    64'h0);
        chk("rst_ovf",   64'(ovf_err),   64'h0);
        chk("rst_cherr", 64'(ch_err),    64'h0);
        chk("rst_count", 64'(cmd_count), 64'h0);

        // Level held high across reset release must not raise a command
        reset_n = 1'b1;
        tick(10);
        chk("arm_valid", 64'(cmd_valid), 64'h0);
        chk("arm_cherr", 64'(ch_err),    64'h0);
        chk("arm_ovf",   64'(ovf_err),   64'h0);
        vs_udr = 1'b0;
        tick(4);

        ir_in  = 2'd2;
        vs_uir = 1'b1;
        tick();
        vs_uir = 1'b0;
        tick(3);
        sr     = W_BEEF;
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        tick();
        chk("lat_early", 64'(cmd_valid), 64'h0);
        tick();
        chk("lat_valid", 64'(cmd_valid), 64'h2);
        chk("lat_jdo",   64'(jdo),       64'(W_BEEF));
        chk("lat_cmdir", 64'(cmd_ir),    64'h2);
        cmd_ready = 2'b10;
        tick();
        cmd_ready = 2'b00;
        chk("hs_valid",  64'(cmd_valid), 64'h0);
        chk("hs_jdo",    64'(jdo),       64'(W_BEEF));

        udr({4'd5, 34'h1});
        chk("bad_cherr", 64'(ch_err),    64'h1);
        chk("bad_valid", 64'(cmd_valid), 64'h0);
        chk("bad_jdo",   64'(jdo),       64'(W_BEEF));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_cherr", 64'(ch_err),    64'h0);

        udr(W_111);
        chk("p4_valid",  64'(cmd_valid), 64'h1);
        cmd_ready = 2'b10;
        udr(W_444);
        cmd_ready = 2'b00;
        chk("ovf_flag",  64'(ovf_err),   64'h1);
        chk("ovf_valid", 64'(cmd_valid), 64'h1);
        chk("ovf_jdo",   64'(jdo),       64'(W_111));
        cmd_ready = 2'b01;
        tick();
        cmd_ready = 2'b00;
        chk("ovf_done",  64'(cmd_valid), 64'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_ovf",   64'(ovf_err),   64'h0);

        // Completion of ch0 coincides with the ch1 update pulse
        udr(W_333);
        chk("rep_first", 64'(cmd_valid), 64'h1);
        sr     = W_444;
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        tick();
        chk("rep_hold",  64'(cmd_valid), 64'h1);
        cmd_ready = 2'b01;
        tick();
        cmd_ready = 2'b00;
        chk("rep_valid", 64'(cmd_valid), 64'h2);
        chk("rep_ovf",   64'(ovf_err),   64'h0);
        chk("rep_jdo",   64'(jdo),       64'(W_444));
        cmd_ready = 2'b10;
        tick();
        cmd_ready = 2'b00;

        // Simultaneous IR and DR update: command takes the previous IR
        ir_in  = 2'd1;
        vs_uir = 1'b1;
        sr     = W_555;
        vs_udr = 1'b1;
        tick();
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        tick(2);
        chk("sim_valid", 64'(cmd_valid), 64'h1);
        chk("sim_cmdir", 64'(cmd_ir),    64'h2);
        cmd_ready = 2'b01;
        tick();
        cmd_ready = 2'b00;
        udr(W_666);
        chk("new_cmdir", 64'(cmd_ir),    64'h1);
        chk("new_valid", 64'(cmd_valid), 64'h2);

        err_clr = 1'b1;
        udr({4'd7, 34'h2});
        chk("clr_race",  64'(ch_err),    64'h1);
        tick();
        err_clr = 1'b0;
        chk("clr_after", 64'(ch_err),    64'h0);
        chk("count",     64'(cmd_count), 64'(exp_cnt));

        // Reset while a command is pending
        reset_n = 1'b0;
        tick();
        chk("mid_valid", 64'(cmd_valid), 64'h0);
        chk("mid_jdo",   64'(jdo),       64'h0);
        chk("mid_count", 64'(cmd_count), 64'h0);
        reset_n = 1'b1;
        tick(5);
        chk("post_valid", 64'(cmd_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
